// File: rtl/hwmod_reset_sequencer_if.sv
// Bundles the core-facing inputs and the sequencer results between hwmod and the openMSP430 reset logic.
// The master modport drives the inputs; the slave modport is the sequencer's view.
interface hwmod_reset_sequencer_if;
    logic [15:0] pc;
    logic        vrased_viol;
    logic        casu_viol;
    logic        upd_valid;
    logic [15:0] upd_er_min;
    logic [15:0] upd_er_max;
    logic        cause_clr;
    logic        reset;
    logic [1:0]  cause;
    logic [7:0]  viol_cnt;
    logic [15:0] ER_min;
    logic [15:0] ER_max;
    logic        upd_ack;
    logic        upd_err;

    modport master (
        output pc, vrased_viol, casu_viol, upd_valid, upd_er_min, upd_er_max, cause_clr,
        input  reset, cause, viol_cnt, ER_min, ER_max, upd_ack, upd_err
    );

    modport slave (
        input  pc, vrased_viol, casu_viol, upd_valid, upd_er_min, upd_er_max, cause_clr,
        output reset, cause, viol_cnt, ER_min, ER_max, upd_ack, upd_err
    );
endinterface

// File: rtl/hwmod_reset_sequencer.sv
// Stretches vrased/casu violations into a registered core reset, tracks cause/count, and gates ER updates to SMEM code.
// All outputs registered (one-cycle latency); no backpressure, upd_ack/upd_err answer every upd_valid the next cycle.
module hwmod_reset_sequencer #(
    parameter logic [15:0] SMEM_BASE     = 16'hA000,
    parameter logic [15:0] SMEM_SIZE     = 16'h4000,
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter int          HOLD_CYCLES   = 8,
    parameter logic [15:0] ER_MIN_RST    = 16'hE000,
    parameter logic [15:0] ER_MAX_RST    = 16'hE000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    hwmod_reset_sequencer_if.slave        seq_if
);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_HOLD      = 2'd1;
    localparam logic [1:0] ST_WAIT_BOOT = 2'd2;

    // Region end computed in 17 bits so a region touching 16'hFFFF cannot wrap.
    localparam logic [16:0] SMEM_LO = {1'b0, SMEM_BASE};
    localparam logic [16:0] SMEM_HI = {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE} - 17'd1;

    logic [1:0]    state_q,    state_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          reset_q,    reset_d;
    logic [1:0]    cause_q,    cause_d;
    logic [7:0]    viol_cnt_q, viol_cnt_d;
    logic [15:0]   er_min_q,   er_min_d;
    logic [15:0]   er_max_q,   er_max_d;
    logic          upd_ack_q,  upd_ack_d;
    logic          upd_err_q,  upd_err_d;

    logic viol;
    logic in_smem;
    logic accept;

    assign viol    = seq_if.vrased_viol | seq_if.casu_viol;
    assign in_smem = ({1'b0, seq_if.pc} >= SMEM_LO) && ({1'b0, seq_if.pc} <= SMEM_HI);
    assign accept  = seq_if.upd_valid && (state_q == ST_RUN) && !viol && in_smem &&
                     (seq_if.upd_er_min <= seq_if.upd_er_max);

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        viol_cnt_d = viol_cnt_q;

        case (state_q)
            ST_HOLD: begin
                if (viol) begin
                    hold_cnt_d = HOLD_LOAD;
                end else if (hold_cnt_q == '0) begin
                    state_d = ST_WAIT_BOOT;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            ST_WAIT_BOOT: begin
                if (viol) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                end else if (seq_if.pc == RESET_HANDLER) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (viol) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                end
            end
        endcase

        // Only fresh entries count; reloads inside HOLD extend the same episode.
        if (viol && (state_q != ST_HOLD) && (viol_cnt_q != 8'hFF)) begin
            viol_cnt_d = viol_cnt_q + 8'd1;
        end

        reset_d = (state_d == ST_HOLD);

        cause_d = cause_q;
        if (viol) begin
            cause_d = cause_q | {seq_if.casu_viol, seq_if.vrased_viol};
        end else if (seq_if.cause_clr && (state_q == ST_RUN)) begin
            cause_d = 2'b00;
        end

        er_min_d  = er_min_q;
        er_max_d  = er_max_q;
        if (accept) begin
            er_min_d = seq_if.upd_er_min;
            er_max_d = seq_if.upd_er_max;
        end
        upd_ack_d = accept;
        upd_err_d = seq_if.upd_valid && !accept;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            hold_cnt_q <= '0;
            reset_q    <= 1'b0;
            cause_q    <= 2'b00;
            viol_cnt_q <= 8'd0;
            er_min_q   <= ER_MIN_RST;
            er_max_q   <= ER_MAX_RST;
            upd_ack_q  <= 1'b0;
            upd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            reset_q    <= reset_d;
            cause_q    <= cause_d;
            viol_cnt_q <= viol_cnt_d;
            er_min_q   <= er_min_d;
            er_max_q   <= er_max_d;
            upd_ack_q  <= upd_ack_d;
            upd_err_q  <= upd_err_d;
        end
    end

    assign seq_if.reset    = reset_q;
    assign seq_if.cause    = cause_q;
    assign seq_if.viol_cnt = viol_cnt_q;
    assign seq_if.ER_min   = er_min_q;
    assign seq_if.ER_max   = er_max_q;
    assign seq_if.upd_ack  = upd_ack_q;
    assign seq_if.upd_err  = upd_err_q;
endmodule

// File: tb/tb_hwmod_reset_sequencer.sv
// Random stimulus against a cycle-index reference model of the reset sequencer.
module tb_hwmod_reset_sequencer;
    localparam int H = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hwmod_reset_sequencer_if sif();

    hwmod_reset_sequencer #(
        .SMEM_BASE(16'hA000), .SMEM_SIZE(16'h4000), .RESET_HANDLER(16'h0000),
        .HOLD_CYCLES(H), .ER_MIN_RST(16'hE000), .ER_MAX_RST(16'hE000)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .seq_if(sif)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: reset is high after edge k while k < hold_end.
    int          k;
    int          hold_end;
    bit          booting;
    bit          exp_rst;
    logic [1:0]  exp_cause;
    int          exp_cnt;
    logic [15:0] exp_min, exp_max;
    bit          exp_ack, exp_err;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, k);
    endtask

    task automatic model_reset();
        k = 0; hold_end = 0; booting = 0; exp_rst = 0;
        exp_cause = 2'b00; exp_cnt = 0;
        exp_min = 16'hE000; exp_max = 16'hE000;
        exp_ack = 0; exp_err = 0;
    endtask

    task automatic model_step();
        bit v, run, in_smem, acc;
        v       = sif.vrased_viol | sif.casu_viol;
        run     = !exp_rst && !booting;
        in_smem = (int'(sif.pc) >= 'hA000) && (int'(sif.pc) <= 'hA000 + 'h4000 - 1);
        acc     = sif.upd_valid && run && !v && in_smem && (sif.upd_er_min <= sif.upd_er_max);
        exp_ack = acc;
        exp_err = sif.upd_valid && !acc;
        if (acc) begin
            exp_min = sif.upd_er_min;
            exp_max = sif.upd_er_max;
        end
        if (v) exp_cause = exp_cause | {sif.casu_viol, sif.vrased_viol};
        else if (sif.cause_clr && run) exp_cause = 2'b00;
        if (v) begin
            if (!exp_rst && exp_cnt < 255) exp_cnt++;
            hold_end = k + H;
            booting  = 1;
        end else if (!exp_rst && booting && sif.pc == 16'h0000) begin
            booting = 0;
        end
        exp_rst = (k < hold_end);
        k++;
    endtask

    task automatic check_all();
        chk("reset",    int'(sif.reset),    int'(exp_rst));
        chk("cause",    int'(sif.cause),    int'(exp_cause));
        chk("viol_cnt", int'(sif.viol_cnt), exp_cnt);
        chk("ER_min",   int'(sif.ER_min),   int'(exp_min));
        chk("ER_max",   int'(sif.ER_max),   int'(exp_max));
        chk("upd_ack",  int'(sif.upd_ack),  int'(exp_ack));
        chk("upd_err",  int'(sif.upd_err),  int'(exp_err));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive_idle();
        sif.pc = 16'h1234; sif.vrased_viol = 0; sif.casu_viol = 0;
        sif.upd_valid = 0; sif.upd_er_min = 0; sif.upd_er_max = 0; sif.cause_clr = 0;
    endtask

    // viol_pct: per-source violation probability in percent.
    task automatic drive_random(input int viol_pct);
        logic [15:0] base;
        case ($urandom_range(0, 7))
            0: sif.pc = 16'h0000;
            1: sif.pc = 16'hA000;
            2: sif.pc = 16'h9FFF;
            3: sif.pc = 16'hDFFF;
            4: sif.pc = 16'hE000;
            5: sif.pc = 16'hA010;
            6: sif.pc = 16'h8000;
            default: sif.pc = 16'($urandom);
        endcase
        sif.vrased_viol = ($urandom_range(0, 99) < viol_pct);
        sif.casu_viol   = ($urandom_range(0, 99) < viol_pct);
        sif.upd_valid   = ($urandom_range(0, 2) == 0);
        sif.cause_clr   = ($urandom_range(0, 7) == 0);
        base = 16'($urandom);
        sif.upd_er_min = base;
        sif.upd_er_max = ($urandom_range(0, 3) == 0) ? 16'($urandom) : base + 16'($urandom_range(0, 64));
    endtask

    initial begin
        drive_idle();
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        reset_n = 1'b1;

        // Mixed traffic: violations, boots, ER updates and cause clears.
        for (int i = 0; i < 3000; i++) begin
            drive_random(3);
            cycle();
        end

        // Separate violation episodes to drive the count into saturation.
        for (int i = 0; i < 300; i++) begin
            drive_random(0);
            sif.casu_viol = 1'b1;
            cycle();
            for (int j = 0; j < H + 2; j++) begin
                drive_random(0);
                cycle();
            end
        end
        chk("viol_cnt_sat", int'(sif.viol_cnt), 255);

        // Asynchronous reset in the middle of a hold window.
        drive_idle();
        sif.vrased_viol = 1'b1;
        cycle();
        drive_idle();
        repeat (3) cycle();
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            drive_random(3);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
